mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between the processor's instruction-fetch path and its data load/store path.
//  Each requester uses a req/gnt/valid handshake. The memory side uses an en/ready handshake with variable latency.
//  Sits between the processor core and the unified memory. Sequences one transaction at a time, with a watchdog per access.
// PARAMETERS
//  ADDR_W   32  address width (matches WORD)
//  DATA_W   32  data width (matches WORD)
//  TMO_CYC  16  max cycles in BUSY waiting for m_ready before abort (>=1)
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       asynchronous, active-low reset
//  if_req    in   1       fetch request; held with if_addr until if_gnt
//  if_addr   in   ADDR_W  fetch address
//  if_gnt    out  1       fetch accepted (1-cycle pulse)
//  if_rdata  out  DATA_W  fetched word; valid when if_valid
//  if_valid  out  1       fetch complete (1-cycle pulse)
//  d_req     in   1       data request; held with d_we/d_addr/d_wdata until d_gnt
//  d_we      in   1       1=store, 0=load
//  d_addr    in   ADDR_W  data address
//  d_wdata   in   DATA_W  store data
//  d_gnt     out  1       data accepted (1-cycle pulse)
//  d_rdata   out  DATA_W  load data; valid when d_valid && !d_we of that txn
//  d_valid   out  1       data txn complete (load or store), 1-cycle pulse
//  m_en      out  1       memory access active
//  m_we      out  1       memory write enable (qualified by m_en)
//  m_addr    out  ADDR_W  memory address
//  m_wdata   out  DATA_W  memory write data
//  m_rdata   in   DATA_W  memory read data, sampled when m_ready
//  m_ready   in   1       memory completes current access this cycle
//  err       out  1       watchdog abort (1-cycle pulse)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, tmo counter=0, last-grant=IF.
//    All outputs 0, incl. if_rdata/d_rdata. m_en drops immediately; any in-flight txn is dropped without valid.
//  - FSM states: IDLE, BUSY_I, BUSY_D.
//  - IDLE: if a request is pending, pick a winner by policy.
//    * Assert the winner's gnt combinationally this cycle.
//    * Latch addr/we/wdata into m_* registers.
//    * Move to BUSY_I or BUSY_D. No req: stay in IDLE.
//  - Grant policy (default): fixed priority; d_req beats if_req. Fetch may starve under continuous data requests.
//  - BUSY_x: m_en=1, m_* stable.
//    * m_ready=1: capture m_rdata (loads/fetches only).
//    * Next cycle: x_valid=1 with x_rdata, state=IDLE.
//    * A store leaves d_rdata unchanged.
//  - Latency: gnt at cycle N; m_en in N+1..; valid one cycle after the m_ready cycle.
//    Zero-wait memory (m_ready in N+1): valid at N+2.
//  - Throughput: a new grant is possible in the same cycle x_valid pulses (state is IDLE then).
//  - Watchdog: tmo counter clears on entry to BUSY and increments each BUSY cycle without m_ready.
//    When it reaches TMO_CYC-1 with m_ready=0: err=1 next cycle, that requester's valid=1 with rdata=0, state=IDLE.
//    m_ready on the limit cycle wins over abort.
//  - m_ready in IDLE is ignored. Requests arriving while BUSY wait (no gnt). Only one gnt per cycle.
//  - m_en, m_we, m_addr, m_wdata, all gnt/valid/err and rdata are registered or state-decoded. No comb path from m_ready to outputs.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    * On a simultaneous if_req and d_req, grant the requester NOT granted last. A last-grant flop updates on each gnt.
//    * A single requester is always granted.
//  ARB_ROUND_ROBIN_EN undefined: fixed data priority as above; no last-grant flop.
// TESTING
//  1 Reset: rst=0 mid-BUSY_D with m_en=1 -> m_en=0 same cycle; after release no d_valid; all outputs 0.
//  2 Fetch, zero-wait: if_req, if_addr=0x10; m_ready at N+1, m_rdata=0xDEADBEEF
//    -> if_gnt@N; m_en@N+1 with m_addr=0x10; if_valid@N+2 with if_rdata=0xDEADBEEF.
//  3 Store, 3 wait: d_we=1, d_addr=0x40, d_wdata=0x1234; m_ready at N+4
//    -> m_we=1 in N+1..N+4; d_valid@N+5; d_rdata unchanged.
//  4 Contention: if_req and d_req both held for 4 txns.
//    -> default: D,D,D,D with if_gnt never.
//    -> ARB_ROUND_ROBIN_EN: D,I,D,I (last-grant=IF after reset).
//  5 Timeout: TMO_CYC=4, m_ready held 0
//    -> m_en for 4 cycles; then err=1, if_valid=1, if_rdata=0, state IDLE.
//    Repeat with m_ready on the 4th BUSY cycle -> normal valid, err=0.
//  6 Back-to-back: d_req re-asserted during the d_valid cycle -> d_gnt in the same cycle; no idle bubble.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between an instruction-fetch
//                requester and a data load/store requester. One transaction
//                is in flight at a time. Each memory access has a watchdog
//                that aborts it after TMO_CYC cycles without m_ready.
//                Optional macro ARB_ROUND_ROBIN_EN selects alternating
//                arbitration on contention. Without it, data requests have
//                fixed priority over fetch requests.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // instruction-fetch requester
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    // data load/store requester
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_valid_o,
    // memory side
    output logic              m_en_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic              m_ready_i,
    // watchdog abort pulse
    output logic              err_o
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_I = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;

    localparam int                c_TMO_W     = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LIMIT = c_TMO_W'(TMO_CYC - 1);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [c_TMO_W-1:0] tmo_q;
    logic               m_we_q;
    logic [ADDR_W-1:0]  m_addr_q;
    logic [DATA_W-1:0]  m_wdata_q;
    logic [DATA_W-1:0]  if_rdata_q;
    logic [DATA_W-1:0]  d_rdata_q;
    logic               if_valid_q;
    logic               d_valid_q;
    logic               err_q;

    logic               w_idle;
    logic               w_pick_d;
    logic               w_pick_i;
    logic               w_tmo_hit;

    assign w_idle    = (state_q == c_IDLE);
    // abort only when the limit is reached and the memory did not answer;
    // a late m_ready on the limit cycle still completes normally
    assign w_tmo_hit = !w_idle && !m_ready_i && (tmo_q == c_TMO_LIMIT);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;   // 1 = data requester won the most recent grant

    // remember who was granted last so contention alternates
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_d_q <= 1'b0;
        end else if (w_idle && (w_pick_d || w_pick_i)) begin
            last_d_q <= w_pick_d;
        end
    end

    assign w_pick_d = d_req_i && (!if_req_i || !last_d_q);
`else
    assign w_pick_d = d_req_i;
`endif
    assign w_pick_i = if_req_i && !w_pick_d;

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic: one transaction at a time, back to IDLE on completion or abort
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_pick_d) begin
                    state_d = c_BUSY_D;
                end else if (w_pick_i) begin
                    state_d = c_BUSY_I;
                end
            end
            c_BUSY_I, c_BUSY_D: begin
                if (m_ready_i || w_tmo_hit) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // output decode: grants are issued only from IDLE, at most one per cycle
    always_comb begin
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        if (state_q == c_IDLE) begin
            if_gnt_o = w_pick_i;
            d_gnt_o  = w_pick_d;
        end
    end

    // datapath: latch the winner's command, run the watchdog, capture read data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q      <= '0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            if (w_idle) begin
                tmo_q <= '0;
                if (w_pick_d) begin
                    m_we_q    <= d_we_i;
                    m_addr_q  <= d_addr_i;
                    m_wdata_q <= d_wdata_i;
                end else if (w_pick_i) begin
                    m_we_q    <= 1'b0;
                    m_addr_q  <= if_addr_i;
                    m_wdata_q <= '0;
                end
            end else if (m_ready_i) begin
                if (state_q == c_BUSY_I) begin
                    if_valid_q <= 1'b1;
                    if_rdata_q <= m_rdata_i;
                end else begin
                    d_valid_q <= 1'b1;
                    if (!m_we_q) begin
                        d_rdata_q <= m_rdata_i;
                    end
                end
            end else if (w_tmo_hit) begin
                err_q <= 1'b1;
                if (state_q == c_BUSY_I) begin
                    if_valid_q <= 1'b1;
                    if_rdata_q <= '0;
                end else begin
                    d_valid_q <= 1'b1;
                    d_rdata_q <= '0;
                end
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign m_en_o     = !w_idle;
    assign m_we_o     = m_we_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
    assign if_rdata_o = if_rdata_q;
    assign if_valid_o = if_valid_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_valid_o  = d_valid_q;
    assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter (TMO_CYC = 4).
//                Directed scenarios plus randomized transactions checked
//                against a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        man_ready = 1'b0;
    logic [31:0] man_rdata = '0;
    bit          mem_auto = 1'b0;
    int          mem_lat = 0;

    logic        if_gnt, if_valid, d_gnt, d_valid, m_en, m_we, err;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        auto_ready = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic [134:0] all_outs;

    int n_checks = 0;
    int n_errors = 0;
    bit m_last_d = 1'b0;   // model: data requester granted last

    assign m_ready  = mem_auto ? auto_ready : man_ready;
    assign m_rdata  = mem_auto ? auto_rdata : man_rdata;
    assign all_outs = {if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
                       m_en, m_we, m_addr, m_wdata, err};

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rdata_o(if_rdata), .if_valid_o(if_valid),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rdata_o(d_rdata), .d_valid_o(d_valid),
        .m_en_o(m_en), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_rdata_i(m_rdata), .m_ready_i(m_ready), .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F;
    endfunction

    // memory responder: answers mem_lat cycles after m_en rises
    logic [31:0] mem [logic [31:0]];
    int rcnt = 0;
    always @(negedge clk) begin
        if (m_en && mem_auto) begin
            if (rcnt == mem_lat) begin
                auto_ready = 1'b1;
                auto_rdata = mem.exists(m_addr) ? mem[m_addr] : pat(m_addr);
                if (m_we) mem[m_addr] = m_wdata;
            end else begin
                auto_ready = 1'b0;
                auto_rdata = '0;
            end
            rcnt++;
        end else begin
            auto_ready = 1'b0;
            rcnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
        man_ready = 1'b0; mem_auto = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_last_d = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        @(negedge clk);
        n_checks++;
        if (all_outs !== '0) begin
            n_errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        tick(); rst_n = 1'b1;
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        @(negedge clk);
        n_checks++;
        if (d_gnt !== 1'b1) begin
            n_errors++; $display("FAIL reset_pre_gnt: d_gnt=%b expected 1", d_gnt);
        end
        tick(); d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_en !== 1'b1) begin
            n_errors++; $display("FAIL reset_busy_en: m_en=%b expected 1", m_en);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_en !== 1'b0 || all_outs !== '0) begin
            n_errors++; $display("FAIL reset_async: m_en=%b outs=%h expected 0", m_en, all_outs);
        end
        tick(); tick(); rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (d_valid === 1'b1 || all_outs !== '0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_errors++; $display("FAIL reset_dropped_txn: saw output activity after reset, expected none");
        end
    endtask

    task automatic test_fetch_zero_wait();
        tick(); if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, d_gnt} !== 2'b10) begin
            n_errors++; $display("FAIL fetch_gnt: {if_gnt,d_gnt}=%b expected 10", {if_gnt, d_gnt});
        end
        tick(); if_req = 1'b0; man_ready = 1'b1; man_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if ({m_en, m_we} !== 2'b10 || m_addr !== 32'h10) begin
            n_errors++; $display("FAIL fetch_mem: en=%b we=%b addr=%h expected 1 0 10", m_en, m_we, m_addr);
        end
        tick(); man_ready = 1'b0; man_rdata = '0;
        @(negedge clk);
        n_checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || err !== 1'b0 || m_en !== 1'b0) begin
            n_errors++; $display("FAIL fetch_valid: valid=%b rdata=%h err=%b en=%b expected 1 deadbeef 0 0",
                                 if_valid, if_rdata, err, m_en);
        end
    endtask

    task automatic test_store_wait3();
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        @(negedge clk);
        tick(); d_req = 1'b0; man_ready = 1'b1; man_rdata = 32'h5555_AAAA;
        @(negedge clk);
        tick(); man_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d_valid !== 1'b1 || d_rdata !== 32'h5555_AAAA) begin
            n_errors++; $display("FAIL load_valid: valid=%b rdata=%h expected 1 5555aaaa", d_valid, d_rdata);
        end
        tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
        @(negedge clk);
        n_checks++;
        if (d_gnt !== 1'b1) begin
            n_errors++; $display("FAIL store_gnt: d_gnt=%b expected 1", d_gnt);
        end
        for (int k = 1; k <= 4; k++) begin
            tick(); d_req = 1'b0; man_ready = (k == 4); man_rdata = 32'hBAD0_BAD0;
            @(negedge clk);
            n_checks++;
            if (m_en !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h40 || m_wdata !== 32'h1234 || d_valid !== 1'b0) begin
                n_errors++; $display("FAIL store_busy_%0d: en=%b we=%b addr=%h wdata=%h valid=%b expected 1 1 40 1234 0",
                                     k, m_en, m_we, m_addr, m_wdata, d_valid);
            end
        end
        tick(); man_ready = 1'b0; man_rdata = '0;
        @(negedge clk);
        n_checks++;
        if (d_valid !== 1'b1 || d_rdata !== 32'h5555_AAAA || err !== 1'b0) begin
            n_errors++; $display("FAIL store_valid: valid=%b rdata=%h err=%b expected 1 5555aaaa 0", d_valid, d_rdata, err);
        end
    endtask

    task automatic test_timeout();
        tick(); if_req = 1'b1; if_addr = 32'h20;
        @(negedge clk);
        for (int k = 1; k <= TMO; k++) begin
            tick(); if_req = 1'b0;
            @(negedge clk);
            n_checks++;
            if (m_en !== 1'b1 || err !== 1'b0 || if_valid !== 1'b0) begin
                n_errors++; $display("FAIL tmo_busy_%0d: en=%b err=%b valid=%b expected 1 0 0", k, m_en, err, if_valid);
            end
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || if_valid !== 1'b1 || if_rdata !== '0 || m_en !== 1'b0) begin
            n_errors++; $display("FAIL tmo_abort: err=%b valid=%b rdata=%h en=%b expected 1 1 0 0", err, if_valid, if_rdata, m_en);
        end
        tick(); if_req = 1'b1; if_addr = 32'h24;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || if_gnt !== 1'b1) begin
            n_errors++; $display("FAIL tmo_err_pulse: err=%b gnt=%b expected 0 1", err, if_gnt);
        end
        for (int k = 1; k <= TMO; k++) begin
            tick(); if_req = 1'b0; man_ready = (k == TMO); man_rdata = 32'hCAFE_F00D;
            @(negedge clk);
        end
        tick(); man_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (if_valid !== 1'b1 || err !== 1'b0 || if_rdata !== 32'hCAFE_F00D) begin
            n_errors++; $display("FAIL tmo_limit_ready: valid=%b err=%b rdata=%h expected 1 0 cafef00d", if_valid, err, if_rdata);
        end
    endtask

    task automatic test_back_to_back();
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
        @(negedge clk);
        tick(); d_req = 1'b0; man_ready = 1'b1; man_rdata = 32'h1111_2222;
        @(negedge clk);
        tick(); man_ready = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h4C;
        #1;
        n_checks++;
        if (d_valid !== 1'b1 || d_gnt !== 1'b1) begin
            n_errors++; $display("FAIL b2b_same_cycle: valid=%b gnt=%b expected 1 1", d_valid, d_gnt);
        end
        tick(); d_req = 1'b0; man_ready = 1'b1; man_rdata = 32'h3333_4444;
        @(negedge clk);
        n_checks++;
        if (m_en !== 1'b1 || m_addr !== 32'h4C) begin
            n_errors++; $display("FAIL b2b_no_bubble: en=%b addr=%h expected 1 4c", m_en, m_addr);
        end
        tick(); man_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d_valid !== 1'b1 || d_rdata !== 32'h3333_4444) begin
            n_errors++; $display("FAIL b2b_second: valid=%b rdata=%h expected 1 33334444", d_valid, d_rdata);
        end
    endtask

    task automatic test_contention();
        bit exp_d, prev_d;
        do_reset();
        mem_auto = 1'b1; mem_lat = 0;
        if_req = 1'b1; if_addr = 32'h60;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
        prev_d = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (cyc % 2 == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_d = !m_last_d;
`else
                exp_d = 1'b1;
`endif
                n_checks++;
                if ({if_gnt, d_gnt} !== {!exp_d, exp_d}) begin
                    n_errors++; $display("FAIL contend_gnt_%0d: {if_gnt,d_gnt}=%b expected %b",
                                         cyc / 2, {if_gnt, d_gnt}, {!exp_d, exp_d});
                end
                if (cyc > 0) begin
                    n_checks++;
                    if ({if_valid, d_valid} !== {!prev_d, prev_d}) begin
                        n_errors++; $display("FAIL contend_valid_%0d: {if_valid,d_valid}=%b expected %b",
                                             cyc / 2, {if_valid, d_valid}, {!prev_d, prev_d});
                    end
                end
                m_last_d = exp_d;
                prev_d = exp_d;
            end else begin
                n_checks++;
                if ({if_gnt, d_gnt} !== 2'b00) begin
                    n_errors++; $display("FAIL contend_busy_gnt: {if_gnt,d_gnt}=%b expected 00", {if_gnt, d_gnt});
                end
            end
        end
        tick(); if_req = 1'b0; d_req = 1'b0;
        tick(); mem_auto = 1'b0;
    endtask

    task automatic test_random();
        bit ifp, dp, win_d, exp_to, got, bad_gnt;
        logic [31:0] t_addr, t_wdata, exp_val, exp_drdata, ref_mem [logic [31:0]];
        bit t_we;
        int lat, cnt, exp_cnt;
        do_reset();
        mem_auto = 1'b1;
        ifp = 1'b0; dp = 1'b0; exp_drdata = '0;
        for (int it = 0; it < 40; it++) begin
            if (!ifp && $urandom_range(0, 1) == 1) begin
                ifp = 1'b1; if_addr = 32'($urandom_range(0, 7)) << 2;
            end
            if (!dp && ($urandom_range(0, 1) == 1 || !ifp)) begin
                dp = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 7)) << 2; d_wdata = $urandom;
            end
            if_req = ifp; d_req = dp;
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            win_d = (dp && ifp) ? !m_last_d : dp;
`else
            win_d = dp;
`endif
            n_checks++;
            if ({if_gnt, d_gnt} !== {!win_d, win_d}) begin
                n_errors++; $display("FAIL rand_gnt_%0d: {if_gnt,d_gnt}=%b expected %b", it, {if_gnt, d_gnt}, {!win_d, win_d});
            end
            m_last_d = win_d;
            t_we = win_d ? d_we : 1'b0;
            t_addr = win_d ? d_addr : if_addr;
            t_wdata = d_wdata;
            lat = $urandom_range(0, 5);
            tick();
            mem_lat = lat;
            if (win_d) begin dp = 1'b0; d_req = 1'b0; end
            else begin ifp = 1'b0; if_req = 1'b0; end
            cnt = 0; got = 1'b0; bad_gnt = 1'b0;
            while (!got && cnt < 20) begin
                @(negedge clk);
                cnt++;
                if (cnt == 1) begin
                    n_checks++;
                    if (m_en !== 1'b1 || m_we !== t_we || m_addr !== t_addr || (t_we && m_wdata !== t_wdata)) begin
                        n_errors++; $display("FAIL rand_cmd_%0d: en=%b we=%b addr=%h wdata=%h expected 1 %b %h %h",
                                             it, m_en, m_we, m_addr, m_wdata, t_we, t_addr, t_wdata);
                    end
                end
                if (if_valid === 1'b1 || d_valid === 1'b1) got = 1'b1;
                else if (if_gnt === 1'b1 || d_gnt === 1'b1) bad_gnt = 1'b1;
            end
            exp_to  = (lat >= TMO);
            exp_cnt = exp_to ? TMO + 1 : lat + 2;
            n_checks++;
            if (!got || cnt != exp_cnt || bad_gnt) begin
                n_errors++; $display("FAIL rand_latency_%0d: got=%b cycles=%0d busy_gnt=%b expected 1 %0d 0",
                                     it, got, cnt, bad_gnt, exp_cnt);
            end
            exp_val = ref_mem.exists(t_addr) ? ref_mem[t_addr] : pat(t_addr);
            if (exp_to) exp_val = '0;
            if (win_d && !(t_we && !exp_to)) exp_drdata = exp_val;
            if (win_d && t_we && !exp_to) ref_mem[t_addr] = t_wdata;
            n_checks++;
            if ({if_valid, d_valid} !== {!win_d, win_d} || err !== exp_to) begin
                n_errors++; $display("FAIL rand_done_%0d: {if_valid,d_valid}=%b err=%b expected %b %b",
                                     it, {if_valid, d_valid}, err, {!win_d, win_d}, exp_to);
            end
            n_checks++;
            if (win_d ? (d_rdata !== exp_drdata) : (if_rdata !== exp_val)) begin
                n_errors++; $display("FAIL rand_rdata_%0d: if_rdata=%h d_rdata=%h expected %h",
                                     it, if_rdata, d_rdata, win_d ? exp_drdata : exp_val);
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (TMO + 3) tick();
    endtask

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_store_wait3();
        test_timeout();
        test_back_to_back();
        test_contention();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
